// File: rtl/fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// Shared types for the instruction-fetch stage.
//   common : machine word types and the instruction size in bytes.
//   pipes  : F/D pipeline register layout and the fetch FSM state encoding.
// No ports; imported by pc_reg and fetch_stage.
// -----------------------------------------------------------------------------
package common;
  typedef logic [63:0] u64;
  typedef logic [31:0] u32;

  localparam int PC_INSTR_BYTES = 4;
endpackage

package pipes;
  import common::*;

  // F/D register consumed by decode.
  typedef struct packed {
    logic valid;
    u64   pc;
    u32   raw_instr;
  } fetch_data_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DROP  = 2'd2,
    HOLD  = 2'd3
  } fetch_state_t;
endpackage

// File: rtl/fetch_stage_pc_reg.sv
// -----------------------------------------------------------------------------
// pc_reg: program counter plus the address of a squashed, still-outstanding
// request.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   i_redirect_valid  load i_redirect_pc into pc (beats increment)
//   i_redirect_pc     redirect target
//   i_advance         pc <= pc + 4
//   i_park            remember the current pc as the outstanding request
//                     address (request squashed before its response arrived)
//   o_pc              current fetch PC
//   o_drop_addr       address still on the bus while the squashed request
//                     drains
// -----------------------------------------------------------------------------
module pc_reg
  import common::*;
#(
  parameter u64 PC_RESET = 64'h0000_0000_8000_0000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_redirect_valid,
  input  u64   i_redirect_pc,
  input  logic i_advance,
  input  logic i_park,
  output u64   o_pc,
  output u64   o_drop_addr
);

  u64 r_pc;
  u64 r_drop_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc        <= PC_RESET;
      r_drop_addr <= '0;
    end else begin
      // pc moves to the new target immediately, so the bus address of the
      // abandoned request has to be kept aside until its response shows up.
      if (i_park) begin
        r_drop_addr <= r_pc;
      end
      if (i_redirect_valid) begin
        r_pc <= i_redirect_pc;
      end else if (i_advance) begin
        r_pc <= r_pc + u64'(PC_INSTR_BYTES);
      end
    end
  end

  assign o_pc        = r_pc;
  assign o_drop_addr = r_drop_addr;

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage: instruction fetch, single outstanding hold-until-done request,
// fills the F/D register consumed by decode.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   ireq_valid, ireq_addr       instruction bus request
//   iresp_data_ok, iresp_data   response, completes the outstanding request
//   stall                       decode cannot take the F/D register
//   redirect_valid, redirect_pc control-flow redirect from execute
//   dataF_valid/pc/raw_instr    F/D register contents
// -----------------------------------------------------------------------------
module fetch_stage
  import common::*;
  import pipes::*;
#(
  parameter u64 PC_RESET = 64'h0000_0000_8000_0000
) (
  input  logic clk,
  input  logic reset,
  output logic ireq_valid,
  output u64   ireq_addr,
  input  logic iresp_data_ok,
  input  u32   iresp_data,
  input  logic stall,
  input  logic redirect_valid,
  input  u64   redirect_pc,
  output logic dataF_valid,
  output u64   dataF_pc,
  output u32   dataF_raw_instr
);

  fetch_state_t r_state;
  fetch_state_t w_state_next;
  fetch_data_t  r_fd;
  u64           w_pc;
  u64           w_drop_addr;
  logic         w_capture;
  logic         w_park;

  // A response is kept only if nothing squashed it in the same cycle.
  assign w_capture = (r_state == FETCH) && iresp_data_ok && !redirect_valid;
  // Squashed before the response: the request must drain in DROP.
  assign w_park    = (r_state == FETCH) && redirect_valid && !iresp_data_ok;

  pc_reg #(
    .PC_RESET(PC_RESET)
  ) u_pc_reg (
    .clk             (clk),
    .reset           (reset),
    .i_redirect_valid(redirect_valid),
    .i_redirect_pc   (redirect_pc),
    .i_advance       (w_capture),
    .i_park          (w_park),
    .o_pc            (w_pc),
    .o_drop_addr     (w_drop_addr)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: w_state_next = FETCH;
      FETCH: begin
        if (redirect_valid) begin
          w_state_next = iresp_data_ok ? FETCH : DROP;
        end else if (iresp_data_ok) begin
          w_state_next = HOLD;
        end
      end
      DROP: begin
        if (iresp_data_ok) begin
          w_state_next = FETCH;
        end
      end
      HOLD: begin
        // Redirect beats stall: the held instruction is on a dead path.
        if (redirect_valid || !stall) begin
          w_state_next = FETCH;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_fd    <= '0;
    end else begin
      r_state <= w_state_next;
      if (redirect_valid) begin
        r_fd.valid <= 1'b0;
      end else if (w_capture) begin
        r_fd <= '{valid: 1'b1, pc: w_pc, raw_instr: iresp_data};
      end else if ((r_state == HOLD) && !stall) begin
        r_fd.valid <= 1'b0;
      end
    end
  end

  assign ireq_valid      = (r_state == FETCH) || (r_state == DROP);
  assign ireq_addr       = (r_state == DROP) ? w_drop_addr : w_pc;
  assign dataF_valid     = r_fd.valid;
  assign dataF_pc        = r_fd.pc;
  assign dataF_raw_instr = r_fd.raw_instr;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam logic [63:0] A0 = 64'h0000_0000_8000_0000;

  logic        clk;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        stall;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        dataF_valid;
  logic [63:0] dataF_pc;
  logic [31:0] dataF_raw_instr;

  fetch_stage #(.PC_RESET(A0)) dut (
    .clk            (clk),
    .reset          (reset),
    .ireq_valid     (ireq_valid),
    .ireq_addr      (ireq_addr),
    .iresp_data_ok  (iresp_data_ok),
    .iresp_data     (iresp_data),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dataF_valid    (dataF_valid),
    .dataF_pc       (dataF_pc),
    .dataF_raw_instr(dataF_raw_instr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [63:0] exp_req_q[$];
  logic [63:0] exp_cap_q[$];
  int          bus_lat = 1;
  bit          bus_en = 1'b1;
  int          bus_cnt = 0;
  logic        prev_valid = 1'b0;
  logic        prev_done = 1'b0;
  logic [63:0] prev_addr = '0;
  logic        prev_dv = 1'b0;

  // Bus memory contents: address 0x8000_0000 holds 32'h0000_0013.
  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return a[31:0] ^ 32'h8000_0013;
  endfunction

  task automatic chk64(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endtask

  // Bus responder and scoreboard monitor, both at the falling edge.
  // Main stimulus runs 1 time unit after the falling edge, so no races.
  initial begin
    forever begin
      @(negedge clk);
      if (bus_en) begin
        if (reset || !ireq_valid) begin
          iresp_data_ok = 1'b0;
          bus_cnt = 0;
        end else if (bus_cnt == bus_lat - 1) begin
          iresp_data_ok = 1'b1;
          iresp_data = instr_of(ireq_addr);
          bus_cnt = 0;
        end else begin
          iresp_data_ok = 1'b0;
          bus_cnt++;
        end
      end
      if (reset) begin
        prev_valid = 1'b0;
        prev_done = 1'b0;
        prev_dv = 1'b0;
      end else begin
        if (prev_valid && !prev_done) begin
          chk1("bus_hold_valid", ireq_valid, 1'b1);
          chk64("bus_hold_addr", ireq_addr, prev_addr);
        end else if (ireq_valid && exp_req_q.size() > 0) begin
          chk64("req_addr", ireq_addr, exp_req_q.pop_front());
        end
        if (dataF_valid && !prev_dv) begin
          $display("capture pc=%h instr=%h", dataF_pc, dataF_raw_instr);
          chk64("cap_instr", 64'(dataF_raw_instr), 64'(instr_of(dataF_pc)));
          if (exp_cap_q.size() > 0) chk64("cap_pc", dataF_pc, exp_cap_q.pop_front());
        end
        prev_valid = ireq_valid;
        prev_done = ireq_valid && iresp_data_ok;
        prev_addr = ireq_addr;
        prev_dv = dataF_valid;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input int lat);
    reset = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    bus_lat = lat;
    bus_en = 1'b1;
    step();
    step();
    chk1("rst_ireq_valid", ireq_valid, 1'b0);
    chk64("rst_ireq_addr", ireq_addr, A0);
    chk1("rst_dataF_valid", dataF_valid, 1'b0);
    chk64("rst_dataF_pc", dataF_pc, 64'd0);
    chk64("rst_dataF_raw", 64'(dataF_raw_instr), 64'd0);
    exp_req_q.delete();
    exp_cap_q.delete();
    reset = 1'b0;
  endtask

  task automatic end_scenario(input string nm);
    chk1({nm, "_req_q_drained"}, exp_req_q.size() == 0, 1'b1);
    chk1({nm, "_cap_q_drained"}, exp_cap_q.size() == 0, 1'b1);
    $display("scenario %s done", nm);
  endtask

  task automatic wait_req(input string nm);
    for (int k = 0; k < 50 && ireq_valid !== 1'b1; k++) step();
    chk1(nm, ireq_valid, 1'b1);
  endtask

  task automatic wait_dv(input string nm);
    for (int k = 0; k < 50 && dataF_valid !== 1'b1; k++) step();
    chk1(nm, dataF_valid, 1'b1);
  endtask

  typedef struct {
    logic        stall;
    logic        redir;
    logic [63:0] rpc;
    logic        exp_rv;
    logic [63:0] exp_addr;
    logic        exp_dv;
    logic [63:0] exp_dpc;
  } vec_t;

  vec_t vecs[9];

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    iresp_data_ok = 1'b0;
    iresp_data = '0;

    // Per-cycle vectors on a 1-cycle bus, starting in IDLE after reset.
    vecs[0] = '{1'b0, 1'b0, 64'd0,             1'b1, A0,                  1'b0, 64'd0};
    vecs[1] = '{1'b0, 1'b0, 64'd0,             1'b0, 64'd0,               1'b1, A0};
    vecs[2] = '{1'b0, 1'b0, 64'd0,             1'b1, A0 + 64'd4,          1'b0, A0};
    vecs[3] = '{1'b0, 1'b0, 64'd0,             1'b0, 64'd0,               1'b1, A0 + 64'd4};
    vecs[4] = '{1'b1, 1'b0, 64'd0,             1'b0, 64'd0,               1'b1, A0 + 64'd4};
    vecs[5] = '{1'b1, 1'b0, 64'd0,             1'b0, 64'd0,               1'b1, A0 + 64'd4};
    vecs[6] = '{1'b1, 1'b1, A0 + 64'h400,      1'b1, A0 + 64'h400,        1'b0, A0 + 64'd4};
    vecs[7] = '{1'b1, 1'b0, 64'd0,             1'b0, 64'd0,               1'b1, A0 + 64'h400};
    vecs[8] = '{1'b0, 1'b0, 64'd0,             1'b1, A0 + 64'h404,        1'b0, A0 + 64'h400};

    step();

    // 1: basic fetch, throughput, redirect during HOLD with stall.
    do_reset(1);
    exp_req_q = '{A0, A0 + 64'd4, A0 + 64'h400, A0 + 64'h404};
    exp_cap_q = '{A0, A0 + 64'd4, A0 + 64'h400};
    for (int i = 0; i < 9; i++) begin
      stall = vecs[i].stall;
      redirect_valid = vecs[i].redir;
      redirect_pc = vecs[i].rpc;
      step();
      $display("vec %0d rv=%b addr=%h dv=%b dpc=%h", i, ireq_valid, ireq_addr, dataF_valid, dataF_pc);
      chk1($sformatf("v%0d_ireq_valid", i), ireq_valid, vecs[i].exp_rv);
      if (vecs[i].exp_rv) chk64($sformatf("v%0d_ireq_addr", i), ireq_addr, vecs[i].exp_addr);
      chk1($sformatf("v%0d_dataF_valid", i), dataF_valid, vecs[i].exp_dv);
      chk64($sformatf("v%0d_dataF_pc", i), dataF_pc, vecs[i].exp_dpc);
    end
    stall = 1'b0;
    redirect_valid = 1'b0;
    end_scenario("table");

    // 2: latency 3, stall 4 cycles after capture.
    do_reset(3);
    exp_req_q = '{A0, A0 + 64'd4};
    exp_cap_q = '{A0};
    wait_dv("s2_capture");
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk1("s2_stall_no_req", ireq_valid, 1'b0);
      chk1("s2_stall_dv", dataF_valid, 1'b1);
      chk64("s2_stall_dpc", dataF_pc, A0);
      chk64("s2_stall_raw", 64'(dataF_raw_instr), 64'h13);
    end
    stall = 1'b0;
    step();
    chk1("s2_resume_req", ireq_valid, 1'b1);
    chk64("s2_resume_addr", ireq_addr, A0 + 64'd4);
    end_scenario("stall");

    // 3: redirect one cycle into a 3-cycle request.
    do_reset(3);
    exp_req_q = '{A0, A0 + 64'h100};
    exp_cap_q = '{A0 + 64'h100};
    wait_req("s3_req");
    step();
    redirect_valid = 1'b1;
    redirect_pc = A0 + 64'h100;
    step();
    redirect_valid = 1'b0;
    chk1("s3_drop_valid", ireq_valid, 1'b1);
    chk64("s3_drop_addr", ireq_addr, A0);
    chk1("s3_drop_dv", dataF_valid, 1'b0);
    step();
    chk1("s3_after_drop_dv", dataF_valid, 1'b0);
    chk64("s3_new_addr", ireq_addr, A0 + 64'h100);
    wait_dv("s3_capture");
    chk64("s3_dpc", dataF_pc, A0 + 64'h100);
    end_scenario("redirect_mid");

    // 4: redirect in the same cycle as data_ok.
    do_reset(2);
    exp_req_q = '{A0, 64'h0000_0001_2345_6780};
    exp_cap_q = '{64'h0000_0001_2345_6780};
    wait_req("s4_req");
    step();
    chk1("s4_data_ok_now", iresp_data_ok, 1'b1);
    redirect_valid = 1'b1;
    redirect_pc = 64'h0000_0001_2345_6780;
    step();
    redirect_valid = 1'b0;
    chk1("s4_dv", dataF_valid, 1'b0);
    chk1("s4_req_valid", ireq_valid, 1'b1);
    chk64("s4_req_addr", ireq_addr, 64'h0000_0001_2345_6780);
    wait_dv("s4_capture");
    chk64("s4_dpc", dataF_pc, 64'h0000_0001_2345_6780);
    end_scenario("redirect_ok");

    // 6a: two redirects while draining in DROP; latest wins.
    do_reset(4);
    exp_req_q = '{A0, 64'h300};
    exp_cap_q = '{64'h300};
    wait_req("s6_req");
    redirect_valid = 1'b1;
    redirect_pc = 64'h200;
    step();
    chk64("s6_drop_addr1", ireq_addr, A0);
    chk1("s6_drop_dv", dataF_valid, 1'b0);
    redirect_pc = 64'h300;
    step();
    redirect_valid = 1'b0;
    chk64("s6_drop_addr2", ireq_addr, A0);
    step();
    step();
    chk1("s6_new_valid", ireq_valid, 1'b1);
    chk64("s6_new_addr", ireq_addr, 64'h300);
    wait_dv("s6_capture");
    chk64("s6_dpc", dataF_pc, 64'h300);
    end_scenario("double_redirect");

    // 6b: reset mid-request, then a late data_ok in IDLE.
    do_reset(3);
    wait_dv("s7_capture");
    wait_req("s7_req");
    reset = 1'b1;
    bus_en = 1'b0;
    iresp_data_ok = 1'b0;
    step();
    chk1("s7_rst_req", ireq_valid, 1'b0);
    chk64("s7_rst_addr", ireq_addr, A0);
    chk1("s7_rst_dv", dataF_valid, 1'b0);
    chk64("s7_rst_dpc", dataF_pc, 64'd0);
    chk64("s7_rst_raw", 64'(dataF_raw_instr), 64'd0);
    reset = 1'b0;
    iresp_data_ok = 1'b1;
    iresp_data = 32'hdead_beef;
    step();
    chk1("s7_late_req", ireq_valid, 1'b1);
    chk64("s7_late_addr", ireq_addr, A0);
    chk1("s7_late_dv", dataF_valid, 1'b0);
    iresp_data_ok = 1'b0;
    step();
    chk1("s7_still_req", ireq_valid, 1'b1);
    chk1("s7_still_dv", dataF_valid, 1'b0);
    end_scenario("reset_mid");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
